adder_result_queue: RTL

//   Downstream stage of the 32-bit pipelined prefix adder. Tracks each operand

---
 rtl/adder_result_queue.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/adder_result_queue.sv
// -----------------------------------------------------------------------------
// adder_result_queue
//
// This is the downstream stage of the pipelined prefix adder. A tag marks each
// operand pair that the upstream stage accepts. The tag travels through a
// LATENCY-deep shift register that runs in step with the adder. When a tag
// reaches the end of that register, the adder's {cout_in, sum_in} is written
// into a small FIFO. The consumer drains the FIFO through a valid/ready
// handshake.
//
// The adder pipe cannot stall, so upstream issue is gated by credit. The
// reserved counter counts in-flight tags plus stored entries. Issue is only
// allowed while that count is below DEPTH, so every in-flight result is
// guaranteed a free FIFO slot when it arrives.
//
// Optional feature macro: RESULT_FLAGS_EN
//   When defined, each FIFO entry also stores a zero flag and a negative flag,
//   both computed from sum_in at push time. These flags appear on res_zero and
//   res_neg. When the macro is undefined, those ports and that storage do not
//   exist.
//
// Parameters
//   WIDTH    sum width, must match the adder
//   LATENCY  cycles from issue accept to valid sum_in/cout_in (>=1)
//   DEPTH    FIFO entries (power of 2, >=2)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   flush        synchronous clear of in-flight tags and FIFO contents
//   issue_valid  upstream presents operands to the adder this cycle
//   issue_ready  credit available; issue fires on issue_valid && issue_ready
//   sum_in       adder sum output
//   cout_in      adder carry-out
//   res_valid    FIFO head valid
//   res_ready    consumer accepts the head
//   res_sum      head sum
//   res_carry    head carry
//   res_zero     head sum was zero        (RESULT_FLAGS_EN only)
//   res_neg      head sum MSB was set     (RESULT_FLAGS_EN only)
//   occupancy    number of entries stored in the FIFO
// -----------------------------------------------------------------------------
module adder_result_queue #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [WIDTH-1:0]       sum_in,
    input  logic                   cout_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_sum,
    output logic                   res_carry,
`ifdef RESULT_FLAGS_EN
    output logic                   res_zero,
    output logic                   res_neg,
`endif
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef RESULT_FLAGS_EN
    localparam int EW = WIDTH + 3;
`else
    localparam int EW = WIDTH + 1;
`endif

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    // Entry layout: {neg, zero, carry, sum} with flags, {carry, sum} without.
    function automatic logic [EW-1:0] pack_entry(input logic [WIDTH-1:0] sum,
                                                 input logic             carry);
`ifdef RESULT_FLAGS_EN
        return {sum[WIDTH-1], (sum == {WIDTH{1'b0}}), carry, sum};
`else
        return {carry, sum};
`endif
    endfunction

    logic [LATENCY-1:0] tag_q,      tag_d;
    logic [PW-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]      count_q,    count_d;
    logic [CW-1:0]      reserved_q, reserved_d;
    logic               wr_en_d;
    logic [EW-1:0]      wr_data_d;
    logic [EW-1:0]      mem_q [DEPTH];

    logic               issue_fire_s;
    logic               push_s;
    logic               pop_s;
    logic [EW-1:0]      head_s;

    // Handshake qualifiers and the head view of the FIFO.
    always_comb begin
        issue_ready  = !reset && !flush && (reserved_q < CNT_MAX);
        issue_fire_s = issue_valid && issue_ready;
        // The oldest tag reaching the end of the pipe means sum_in/cout_in are valid now.
        push_s       = tag_q[LATENCY-1];
        res_valid    = (count_q != {CW{1'b0}});
        pop_s        = res_valid && res_ready;
        head_s       = mem_q[rd_ptr_q];
        res_sum      = head_s[WIDTH-1:0];
        res_carry    = head_s[WIDTH];
`ifdef RESULT_FLAGS_EN
        res_zero     = head_s[WIDTH+1];
        res_neg      = head_s[WIDTH+2];
`endif
        occupancy    = count_q;
    end

    // Next-state logic for tag pipe, pointers, occupancy and credit.
    always_comb begin
        tag_d      = tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        reserved_d = reserved_q;
        wr_en_d    = 1'b0;
        wr_data_d  = pack_entry(sum_in, cout_in);

        if (flush) begin
            // Flush discards everything, including any push, pop or issue in this cycle.
            tag_d      = {LATENCY{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            count_d    = {CW{1'b0}};
            reserved_d = {CW{1'b0}};
        end else begin
            tag_d[0] = issue_fire_s;
            for (int i = 1; i < LATENCY; i++) begin
                tag_d[i] = tag_q[i-1];
            end

            wr_en_d = push_s;
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            // Credit is taken at issue and returned only when the consumer pops.
            case ({issue_fire_s, pop_s})
                2'b10:   reserved_d = reserved_q + CNT_ONE;
                2'b01:   reserved_d = reserved_q - CNT_ONE;
                default: reserved_d = reserved_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q      <= {LATENCY{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            reserved_q <= {CW{1'b0}};
        end else begin
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            reserved_q <= reserved_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
        end else if (wr_en_d) begin
            mem_q[wr_ptr_q] <= wr_data_d;
        end
    end

endmodule
